fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch.sv | 120 ++++++++++++
 tb/tb_fetch.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM encoding, NOP, opcodes,
// buffer entry layout and PC alignment helper.
package fetch_pkg;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_DROP = 1'b1;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small register FIFO holding fetched {pc, instruction} pairs.
// Output is taken straight from storage registers.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q;
    logic [PW-1:0]    wr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer, count and storage update; flush only resets bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata;
                wr_q        <= nxt(wr_q);
            end
            if (do_pop) rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: single-outstanding memory requester,
// redirect handling with stale-response drop, and decode buffer.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] instruction_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [0:0]   state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  target_q, target_d;
    logic         req_q, req_d;
    logic [31:0]  redir_tgt;
    logic         push, pop, flush;
    logic         fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW:0]  occ_next;
    fetch_entry_t wr_entry, rd_entry;

    assign imem_req         = req_q;
    assign imem_addr        = pc_q;
    assign inst_valid       = ~fifo_empty;
    assign instruction_data = rd_entry.inst;
    assign inst_pc          = rd_entry.pc;
    assign pop              = inst_ready & ~fifo_empty;
    assign redir_tgt        = word_align(redirect_pc);
    assign wr_entry         = '{pc: pc_q, inst: imem_rdata};
    assign occ_next         = {1'b0, fifo_count}
                            + {{CW{1'b0}}, push}
                            - {{CW{1'b0}}, pop};

    // Next-state, fetch PC and request decisions
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        req_d    = req_q;
        push     = 1'b0;
        flush    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    req_d = 1'b1;
                    if (!req_q || imem_ack) begin
                        pc_d = redir_tgt;
                    end else begin
                        target_d = redir_tgt;
                        state_d  = ST_DROP;
                    end
                end else begin
                    if (req_q && imem_ack) begin
                        push = ~fifo_full;
                        pc_d = pc_q + 32'd4;
                    end
                    if (!req_q || imem_ack)
                        req_d = (occ_next < (CW+1)'(FIFO_DEPTH));
                end
            end
            ST_DROP: begin
                flush = redirect_valid;
                if (redirect_valid) target_d = redir_tgt;
                if (imem_ack) begin
                    pc_d    = redirect_valid ? redir_tgt : target_q;
                    req_d   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Fetch control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            target_q <= RESET_PC;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            req_q    <= req_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (wr_entry),
        .pop     (pop),
        .flush   (flush),
        .rdata   (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch stage: directed scenarios
// plus a randomized run against a stream-level reference model.
module tb_fetch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] instruction_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    int total = 0;
    int bad = 0;
    int wait_cfg = 0;
    bit wait_rand = 0;
    int wcnt = 0;
    bit in_txn = 0;

    fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .inst_valid       (inst_valid),
        .instruction_data (instruction_data),
        .inst_pc          (inst_pc),
        .inst_ready       (inst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        imem_ack = 1'b0;
    endtask

    task automatic drive_mem();
        if (imem_req) begin
            if (!in_txn) begin
                in_txn = 1;
                wcnt = wait_rand ? int'($urandom_range(0, 3)) : wait_cfg;
            end
            if (wcnt == 0) begin
                imem_ack = 1'b1;
                imem_rdata = memf(imem_addr);
                in_txn = 0;
            end else begin
                imem_ack = 1'b0;
                imem_rdata = $urandom;
                wcnt--;
            end
        end else begin
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            in_txn = 0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        redirect_valid = 1'b0;
        imem_ack = 1'b0;
        in_txn = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        total++; if (instruction_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", instruction_data); end
        total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", inst_pc); end
        reset_n = 1'b1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rel_c0_req: got %b want 0", imem_req); end
        tick();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rel_c1_req: got %b want 1", imem_req); end
    endtask

    task automatic test_stream();
        wait_rand = 0; wait_cfg = 0; inst_ready = 1'b1;
        do_reset();
        drive_mem(); tick();
        for (int c = 1; c < 8; c++) begin
            total++;
            if (imem_req !== 1'b1 || imem_addr !== 32'((c - 1) * 4)) begin
                bad++; $display("FAIL stream_addr c%0d: got req=%b addr=%h want 1 %h", c, imem_req, imem_addr, (c - 1) * 4);
            end
            if (c >= 2) begin
                total++;
                if (inst_valid !== 1'b1 || inst_pc !== 32'((c - 2) * 4) || instruction_data !== memf(32'((c - 2) * 4))) begin
                    bad++; $display("FAIL stream_inst c%0d: got v=%b pc=%h d=%h want pc=%h", c, inst_valid, inst_pc, instruction_data, (c - 2) * 4);
                end
            end
            drive_mem(); tick();
        end
    endtask

    task automatic test_backpressure();
        int acks;
        wait_rand = 0; wait_cfg = 0; inst_ready = 1'b0;
        do_reset();
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            drive_mem();
            if (imem_ack) acks++;
            tick();
        end
        total++; if (acks !== 2) begin bad++; $display("FAIL bp_count: got %0d want 2", acks); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req: got %b want 0", imem_req); end
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || instruction_data !== memf(32'h0)) begin
            bad++; $display("FAIL bp_first: got v=%b pc=%h d=%h want pc=0", inst_valid, inst_pc, instruction_data);
        end
        inst_ready = 1'b1;
        drive_mem(); tick();
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || instruction_data !== memf(32'h4)) begin
            bad++; $display("FAIL bp_second: got v=%b pc=%h d=%h want pc=4", inst_valid, inst_pc, instruction_data);
        end
    endtask

    task automatic wait_first(input logic [31:0] want, input string name);
        bit seen;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (inst_valid === 1'b1) begin
                seen = 1;
                total++;
                if (inst_pc !== want || instruction_data !== memf(want)) begin
                    bad++; $display("FAIL %s: got pc=%h d=%h want pc=%h", name, inst_pc, instruction_data, want);
                end
            end else begin
                drive_mem(); tick();
            end
        end
        if (!seen) begin
            total++; bad++; $display("FAIL %s: timeout got no inst want pc=%h", name, want);
        end
    endtask

    task automatic test_redirect_drop();
        wait_rand = 0; wait_cfg = 3; inst_ready = 1'b1;
        do_reset();
        drive_mem(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        drive_mem(); tick();
        for (int c = 2; c <= 4; c++) begin
            total++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
                bad++; $display("FAIL drop_hold c%0d: got req=%b addr=%h v=%b want 1 0 0", c, imem_req, imem_addr, inst_valid);
            end
            drive_mem(); tick();
        end
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL drop_next: got req=%b addr=%h v=%b want 1 100 0", imem_req, imem_addr, inst_valid);
        end
        wait_first(32'h100, "drop_first");
    endtask

    task automatic test_double_redirect();
        wait_rand = 0; wait_cfg = 3; inst_ready = 1'b1;
        do_reset();
        drive_mem(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        drive_mem(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        drive_mem(); tick();
        drive_mem(); tick();
        drive_mem(); tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            bad++; $display("FAIL dbl_addr: got req=%b addr=%h want 1 300", imem_req, imem_addr);
        end
        wait_first(32'h300, "dbl_first");
    endtask

    task automatic test_wrap();
        wait_rand = 0; wait_cfg = 0; inst_ready = 1'b1;
        do_reset();
        drive_mem(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        drive_mem(); tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || inst_valid !== 1'b0) begin
            bad++; $display("FAIL wrap_a: got req=%b addr=%h v=%b want 1 fffffffc 0", imem_req, imem_addr, inst_valid);
        end
        drive_mem(); tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL wrap_b: got req=%b addr=%h want 1 0", imem_req, imem_addr);
        end
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || instruction_data !== memf(32'hFFFF_FFFC)) begin
            bad++; $display("FAIL wrap_inst: got v=%b pc=%h d=%h want pc=fffffffc", inst_valid, inst_pc, instruction_data);
        end
    endtask

    task automatic test_reset_mid();
        wait_rand = 0; wait_cfg = 0; inst_ready = 1'b1;
        do_reset();
        drive_mem(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        drive_mem(); tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            bad++; $display("FAIL mid_pre: got req=%b addr=%h want 1 40", imem_req, imem_addr);
        end
        wait_cfg = 5;
        drive_mem(); tick();
        drive_mem(); tick();
        reset_n = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 32'h0 || inst_pc !== 32'h0 || instruction_data !== 32'h0) begin
            bad++; $display("FAIL mid_rst: got req=%b v=%b addr=%h pc=%h d=%h want all 0", imem_req, inst_valid, imem_addr, inst_pc, instruction_data);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        in_txn = 0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL mid_c0: got req=%b want 0", imem_req); end
        tick();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL mid_c1: got req=%b addr=%h v=%b want 1 0 0", imem_req, imem_addr, inst_valid);
        end
        wait_cfg = 0;
        wait_first(32'h0, "mid_first");
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] pa;
        bit pw;
        int delivered;
        wait_rand = 1; inst_ready = 1'b1;
        do_reset();
        exp_pc = 32'h0; pa = '0; pw = 0; delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            if (pw) begin
                total++;
                if (imem_req !== 1'b1 || imem_addr !== pa) begin
                    bad++; if (bad < 20) $display("FAIL rnd_hold: got req=%b addr=%h want 1 %h", imem_req, imem_addr, pa);
                end
            end
            if (imem_req === 1'b1) begin
                total++;
                if (imem_addr[1:0] !== 2'b00) begin
                    bad++; if (bad < 20) $display("FAIL rnd_align: got addr=%h want aligned", imem_addr);
                end
            end
            inst_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 1) != 0) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            if (inst_valid === 1'b1 && inst_ready) begin
                total++;
                if (inst_pc !== exp_pc || instruction_data !== memf(exp_pc)) begin
                    bad++; if (bad < 20) $display("FAIL rnd_inst: got pc=%h d=%h want pc=%h d=%h", inst_pc, instruction_data, exp_pc, memf(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
            drive_mem();
            pw = (imem_req === 1'b1) && !imem_ack;
            pa = imem_addr;
            tick();
        end
        total++;
        if (delivered < 300) begin
            bad++; $display("FAIL rnd_progress: got %0d delivered want >=300", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_double_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
